switch_alloc_rr: RTL and testbench
==================================

// Module: switch_alloc_rr
// PURPOSE
//  Parametrised switch allocator for the mesh NoC router, successor to the fixed-priority 4x4 controller.
//  Each input requests one output; each output has a round-robin arbiter, so contending inputs are served fairly.
//  The winning path is held until the input signals tail-flit relieve.
//  Drives the crossbar select lines and the per-input reservation status.
// PARAMETERS
//  INPUTS       5     number of router input ports (>=2)
//  OUTPUTS      5     number of router output ports (>=2)
//  REQ_W        $clog2(OUTPUTS)  width of one destination request field
//  SEL_W        $clog2(INPUTS)   width of one crossbar select field
//  WDOG_CYCLES  1024  hold-timeout limit, used only with SA_WATCHDOG_EN
// PORTS
//  clk           in   1              clock, rising edge
//  rst           in   1              synchronous, active-high reset
//  req_valid     in   INPUTS         input i requests a path
//  req_dest      in   INPUTS*REQ_W   destination output of input i; stable while req_valid
//  relieve       in   INPUTS         tail flit sent on input i; release its path
//  grant         out  INPUTS         one-cycle pulse when input i wins its output
//  reserved      out  INPUTS         input i holds a path (state HOLD)
//  route_select  out  OUTPUTS*SEL_W  input index connected to output o
//  output_busy   out  OUTPUTS        output o is locked to an input
//  wdog_err      out  INPUTS         one-cycle pulse on forced release (0 without SA_WATCHDOG_EN)
// BEHAVIOUR
//  Reset: all per-input FSMs go to IDLE; grant, reserved, output_busy, route_select and wdog_err are 0; RR pointers are 0.
//  Per-input FSM states: IDLE, WAIT, GRANT, HOLD.
//   IDLE  -> WAIT when req_valid[i]=1 and req_dest < OUTPUTS. A destination >= OUTPUTS is ignored and the FSM stays IDLE.
//   WAIT  -> IDLE if req_valid drops.
//   WAIT  -> GRANT when output req_dest is free and arbiter[req_dest] selects i.
//   WAIT  -> WAIT otherwise.
//   GRANT -> HOLD unconditionally. grant[i]=1 only in GRANT.
//   HOLD  -> IDLE when relieve[i]=1. reserved[i]=1 only in HOLD.
//  Arbitration (combinational, per output o):
//   - Candidates are inputs in WAIT with req_dest==o, considered only while output_busy[o]=0.
//   - Winner is the first candidate at or after rr_ptr[o], searching upward with wrap.
//   - At the edge that moves the winner to GRANT: output_busy[o]<=1, route_select[o]<=winner, rr_ptr[o]<=winner+1 (wrap to 0 at INPUTS).
//   - At most one grant per output per cycle. Different outputs grant in the same cycle independently.
//  Release:
//   - output_busy[o] clears at the edge where the owning input (route_select[o]) is in HOLD with relieve=1.
//   - route_select[o] keeps its last value after release.
//   - relieve in any state other than HOLD is ignored.
//  Latency: uncontended request with req_valid asserted at cycle t -> WAIT at t+1, grant pulse at t+2, reserved from t+3.
//  Simultaneous release and new request for the same output: busy clears at edge e; the waiting input can win at e, grant at e+1.
//   An output is never granted in the same cycle it is released.
//  Reset mid-operation: all paths drop immediately and RR pointers return to 0. No grant is emitted in the reset cycle.
//  Invariant: output_busy[o] is 1 exactly when one input is in GRANT or HOLD with req_dest==o.
// CONFIGURATION
//  SA_WATCHDOG_EN defined:
//   - A per-input counter increments each cycle in HOLD and clears on any other state.
//   - When the count reaches WDOG_CYCLES-1 without relieve: force HOLD->IDLE, clear the output's busy bit, pulse wdog_err[i] for one cycle.
//  SA_WATCHDOG_EN undefined: no counters; wdog_err tied to 0; HOLD lasts until relieve.
// STRUCTURE
//  Package sa_pkg: sa_state_e enum (IDLE=0, WAIT=1, GRANT=2, HOLD=3); STATE_W=2; helper function clog2_min1.
//  Sub-module sa_rr_arbiter (N requests, pointer in, one-hot grant plus index out), instantiated once per output in a generate loop.
//  The top level holds the FSMs, busy/select registers, pointers and the optional watchdog.
// TESTING
//  1. Single path, 5x5: in2 requests out3 at cycle 1 -> grant[2] at cycle 3, route_select[3]=2, output_busy=5'b01000; relieve at cycle 6 -> busy=0 at cycle 7.
//  2. Contention: in0, in1 and in4 request out1 together with rr_ptr=0 -> grant order in0, in1, in4, each after the previous relieve. rr_ptr[1] ends at 0.
//  3. Fairness: in0 re-requests out1 immediately after each relieve while in3 waits -> in3 is granted before in0's second grant.
//  4. Parallel paths: in0->out4 and in1->out2 at the same cycle -> both grant in the same cycle; busy=5'b10100.
//  5. Edge cases: req_dest=6 with OUTPUTS=5 -> FSM stays IDLE and no grant.
//     req_valid dropped in WAIT -> returns to IDLE; the arbiter skips it.
//     rst asserted during HOLD -> all outputs 0 on the next cycle.
//  6. SA_WATCHDOG_EN with WDOG_CYCLES=8: hold without relieve -> wdog_err pulses after 8 HOLD cycles, busy clears, a waiting requester is granted one cycle later.

Source files
------------

// File: rtl/sa_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | sa_pkg: shared types and helpers for the switch_alloc_rr allocator.     |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package sa_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        GRANT = 2'd2,
        HOLD  = 2'd3
    } sa_state_e;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sa_rr_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | sa_rr_arbiter: first requester at or after ptr (wrapping) wins.         |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module sa_rr_arbiter #(
    parameter int N     = 5,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] w_cand;

    function automatic int wrap_idx(input int base, input int off);
        return (base + off >= N) ? base + off - N : base + off;
    endfunction

    always_comb begin
        gnt    = '0;
        idx    = '0;
        any    = 1'b0;
        w_cand = '0;
        for (int off = 0; off < N; off++) begin
            w_cand = IDX_W'(wrap_idx(int'(ptr), off));
            if (!any && req[w_cand]) begin
                any         = 1'b1;
                gnt[w_cand] = 1'b1;
                idx         = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/switch_alloc_rr.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | switch_alloc_rr: per-output round-robin switch allocator with path hold.|
// | Optional hold watchdog enabled by defining SA_WATCHDOG_EN.   Rev 1.0    |
// +-------------------------------------------------------------------------+
module switch_alloc_rr
    import sa_pkg::*;
#(
    parameter int INPUTS      = 5,
    parameter int OUTPUTS     = 5,
    parameter int REQ_W       = clog2_min1(OUTPUTS),
    parameter int SEL_W       = clog2_min1(INPUTS),
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INPUTS-1:0]        req_valid,
    input  logic [INPUTS*REQ_W-1:0]  req_dest,
    input  logic [INPUTS-1:0]        relieve,
    output logic [INPUTS-1:0]        grant,
    output logic [INPUTS-1:0]        reserved,
    output logic [OUTPUTS*SEL_W-1:0] route_select,
    output logic [OUTPUTS-1:0]       output_busy,
    output logic [INPUTS-1:0]        wdog_err
);

    sa_state_e              r_state     [INPUTS];
    sa_state_e              w_state_nxt [INPUTS];
    logic [REQ_W-1:0]       w_dest      [INPUTS];
    logic [INPUTS-1:0]      w_dest_ok, w_win, w_release, w_wdog_fire;
    logic [INPUTS-1:0]      w_cand      [OUTPUTS];
    logic [INPUTS-1:0]      w_arb_gnt   [OUTPUTS];
    logic [SEL_W-1:0]       w_arb_idx   [OUTPUTS];
    logic [OUTPUTS-1:0]     w_arb_any, w_out_release;
    logic [SEL_W-1:0]       r_rr_ptr    [OUTPUTS];
    logic [OUTPUTS-1:0]     r_busy;
    logic [OUTPUTS*SEL_W-1:0] r_route_select;

    always_comb begin
        for (int i = 0; i < INPUTS; i++) begin
            w_dest[i]    = req_dest[i*REQ_W +: REQ_W];
            w_dest_ok[i] = (int'(w_dest[i]) < OUTPUTS);
            w_release[i] = (r_state[i] == HOLD) && (relieve[i] || w_wdog_fire[i]);
        end
    end

    // Only waiting inputs that still assert req_valid compete, and only for free outputs.
    always_comb begin
        for (int o = 0; o < OUTPUTS; o++) begin
            for (int i = 0; i < INPUTS; i++) begin
                w_cand[o][i] = (r_state[i] == WAIT) && req_valid[i] &&
                               (int'(w_dest[i]) == o) && !r_busy[o];
            end
        end
    end

    for (genvar o = 0; o < OUTPUTS; o++) begin : g_arb
        sa_rr_arbiter #(
            .N     (INPUTS),
            .IDX_W (SEL_W)
        ) u_arb (
            .req (w_cand[o]),
            .ptr (r_rr_ptr[o]),
            .gnt (w_arb_gnt[o]),
            .idx (w_arb_idx[o]),
            .any (w_arb_any[o])
        );
    end

    always_comb begin
        w_win         = '0;
        w_out_release = '0;
        for (int o = 0; o < OUTPUTS; o++) begin
            w_win = w_win | w_arb_gnt[o];
            for (int i = 0; i < INPUTS; i++) begin
                if (r_busy[o] && w_release[i] &&
                    (r_route_select[o*SEL_W +: SEL_W] == SEL_W'(i)))
                    w_out_release[o] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < INPUTS; i++) begin
            w_state_nxt[i] = r_state[i];
            case (r_state[i])
                IDLE:    if (req_valid[i] && w_dest_ok[i]) w_state_nxt[i] = WAIT;
                WAIT: begin
                    if (!req_valid[i])  w_state_nxt[i] = IDLE;
                    else if (w_win[i])  w_state_nxt[i] = GRANT;
                end
                GRANT:   w_state_nxt[i] = HOLD;
                HOLD:    if (w_release[i]) w_state_nxt[i] = IDLE;
                default: w_state_nxt[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < INPUTS; i++) r_state[i] <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant and release are mutually exclusive per output: arbitration needs busy=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy         <= '0;
            r_route_select <= '0;
            for (int o = 0; o < OUTPUTS; o++) r_rr_ptr[o] <= '0;
        end else begin
            for (int o = 0; o < OUTPUTS; o++) begin
                if (w_arb_any[o]) begin
                    r_busy[o]                        <= 1'b1;
                    r_route_select[o*SEL_W +: SEL_W] <= w_arb_idx[o];
                    r_rr_ptr[o] <= (w_arb_idx[o] == SEL_W'(INPUTS-1)) ? '0 : w_arb_idx[o] + 1'b1;
                end else if (w_out_release[o]) begin
                    r_busy[o] <= 1'b0;
                end
            end
        end
    end

`ifdef SA_WATCHDOG_EN
    localparam int WDOG_W = clog2_min1(WDOG_CYCLES);

    logic [WDOG_W-1:0] r_wdog_cnt [INPUTS];
    logic [INPUTS-1:0] r_wdog_err;

    always_comb begin
        for (int i = 0; i < INPUTS; i++) begin
            w_wdog_fire[i] = (r_state[i] == HOLD) && !relieve[i] &&
                             (r_wdog_cnt[i] == WDOG_W'(WDOG_CYCLES-1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog_err <= '0;
            for (int i = 0; i < INPUTS; i++) r_wdog_cnt[i] <= '0;
        end else begin
            r_wdog_err <= w_wdog_fire;
            for (int i = 0; i < INPUTS; i++) begin
                if ((r_state[i] == HOLD) && !w_release[i])
                    r_wdog_cnt[i] <= r_wdog_cnt[i] + 1'b1;
                else
                    r_wdog_cnt[i] <= '0;
            end
        end
    end

    assign wdog_err = r_wdog_err;
`else
    assign w_wdog_fire = '0;
    assign wdog_err    = '0;
`endif

    always_comb begin
        for (int i = 0; i < INPUTS; i++) begin
            grant[i]    = (r_state[i] == GRANT);
            reserved[i] = (r_state[i] == HOLD);
        end
    end

    assign output_busy  = r_busy;
    assign route_select = r_route_select;

endmodule
`default_nettype wire

// File: tb/tb_switch_alloc_rr.sv
`default_nettype none
// Bench for switch_alloc_rr (5x5): allocation model compared every cycle plus directed literal checks.
module tb_switch_alloc_rr;

    localparam int N  = 5;
    localparam int M  = 5;
    localparam int RW = 3;
    localparam int SW = 3;
    localparam int WD = 8;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*RW-1:0] req_dest;
    logic [N-1:0]    relieve;
    logic [N-1:0]    grant;
    logic [N-1:0]    reserved;
    logic [M*SW-1:0] route_select;
    logic [M-1:0]    output_busy;
    logic [N-1:0]    wdog_err;

    int checks = 0;
    int errors = 0;

    switch_alloc_rr #(
        .INPUTS      (N),
        .OUTPUTS     (M),
        .REQ_W       (RW),
        .SEL_W       (SW),
        .WDOG_CYCLES (WD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_dest     (req_dest),
        .relieve      (relieve),
        .grant        (grant),
        .reserved     (reserved),
        .route_select (route_select),
        .output_busy  (output_busy),
        .wdog_err     (wdog_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    bit m_wait [N];
    bit m_gnt  [N];
    bit m_hold [N];
    bit m_wdog [N];
    int m_hcnt [N];
    int m_owner[M];
    int m_sel  [M];
    int m_ptr  [M];
    int win    [M];
    bit started = 0;

    logic [N-1:0]    exp_grant, exp_res, exp_wdog;
    logic [M-1:0]    exp_busy;
    logic [M*SW-1:0] exp_sel;

    function automatic bit fire(input int i);
`ifdef SA_WATCHDOG_EN
        return m_hold[i] && !relieve[i] && (m_hcnt[i] == WD-1);
`else
        return 1'b0;
`endif
    endfunction

    always_comb begin
        for (int o = 0; o < M; o++) begin
            win[o] = -1;
            if (m_owner[o] < 0) begin
                for (int k = 0; k < N; k++) begin
                    if (win[o] < 0 && m_wait[(m_ptr[o]+k)%N] && req_valid[(m_ptr[o]+k)%N] &&
                        int'(req_dest[((m_ptr[o]+k)%N)*RW +: RW]) == o)
                        win[o] = (m_ptr[o]+k)%N;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            started <= 1'b1;
            for (int i = 0; i < N; i++) begin
                m_wait[i] <= 0; m_gnt[i] <= 0; m_hold[i] <= 0; m_wdog[i] <= 0; m_hcnt[i] <= 0;
            end
            for (int o = 0; o < M; o++) begin
                m_owner[o] <= -1; m_sel[o] <= 0; m_ptr[o] <= 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (m_wait[i]) begin
                    if (!req_valid[i]) m_wait[i] <= 0;
                    else for (int o = 0; o < M; o++)
                        if (win[o] == i) begin m_wait[i] <= 0; m_gnt[i] <= 1; end
                end else if (m_gnt[i]) begin
                    m_gnt[i] <= 0; m_hold[i] <= 1;
                end else if (m_hold[i]) begin
                    if (relieve[i] || fire(i)) m_hold[i] <= 0;
                end else if (req_valid[i] && int'(req_dest[i*RW +: RW]) < M) begin
                    m_wait[i] <= 1;
                end
                m_wdog[i] <= fire(i);
                m_hcnt[i] <= (m_hold[i] && !relieve[i] && !fire(i)) ? m_hcnt[i] + 1 : 0;
            end
            for (int o = 0; o < M; o++) begin
                if (win[o] >= 0) begin
                    m_owner[o] <= win[o]; m_sel[o] <= win[o]; m_ptr[o] <= (win[o] + 1) % N;
                end else if (m_owner[o] >= 0 && m_hold[m_owner[o]] &&
                             (relieve[m_owner[o]] || fire(m_owner[o]))) begin
                    m_owner[o] <= -1;
                end
            end
        end
    end

    always_comb begin
        exp_grant = '0; exp_res = '0; exp_wdog = '0; exp_busy = '0; exp_sel = '0;
        for (int i = 0; i < N; i++) begin
            exp_grant[i] = m_gnt[i];
            exp_res[i]   = m_hold[i];
            exp_wdog[i]  = m_wdog[i];
        end
        for (int o = 0; o < M; o++) begin
            exp_busy[o]           = (m_owner[o] >= 0);
            exp_sel[o*SW +: SW]   = SW'(m_sel[o]);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("model_grant",    grant,        exp_grant);
            check("model_reserved", reserved,     exp_res);
            check("model_busy",     output_busy,  exp_busy);
            check("model_select",   route_select, exp_sel);
            check("model_wdog",     wdog_err,     exp_wdog);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int i, input int d);
        req_valid[i]          = 1'b1;
        req_dest[i*RW +: RW]  = RW'(d);
    endtask

    task automatic wait_grant(output int idx);
        idx = -1;
        for (int n = 0; n < 30 && idx < 0; n++) begin
            @(negedge clk);
            if (|grant) begin
                for (int k = N-1; k >= 0; k--) if (grant[k]) idx = k;
            end else begin
                next_cycle();
            end
        end
        if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: no grant within 30 cycles (t=%0t)", $time);
        end
    endtask

    task automatic serve(input int idx, input bit keep);
        if (idx >= 0) begin
            next_cycle();
            relieve[idx] = 1'b1;
            if (!keep) req_valid[idx] = 1'b0;
            next_cycle();
            relieve[idx] = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int g;
        int order[3];
        rst = 1'b1; req_valid = '0; req_dest = '0; relieve = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_grant", grant, 0);
        check("reset_busy", output_busy, 0);
        check("reset_select", route_select, 0);

        // Single path in2 -> out3
        next_cycle();                        // cycle 1
        req(2, 3);
        next_cycle();                        // cycle 2
        next_cycle();                        // cycle 3
        req_valid[2] = 1'b0;
        @(negedge clk);
        check("t1_grant", grant, 5'b00100);
        check("t1_sel3", route_select[3*SW +: SW], 2);
        check("t1_busy", output_busy, 5'b01000);
        next_cycle();                        // cycle 4
        @(negedge clk);
        check("t1_reserved", reserved, 5'b00100);
        next_cycle();                        // cycle 5
        next_cycle();                        // cycle 6
        relieve[2] = 1'b1;
        next_cycle();                        // cycle 7
        relieve[2] = 1'b0;
        @(negedge clk);
        check("t1_busy_clear", output_busy, 0);

        // Contention on out1: in0, in1, in4
        next_cycle();
        req(0, 1); req(1, 1); req(4, 1);
        for (int s = 0; s < 3; s++) begin
            wait_grant(g);
            order[s] = g;
            serve(g, 0);
        end
        check("t2_first", order[0], 0);
        check("t2_second", order[1], 1);
        check("t2_third", order[2], 4);

        // Pointer on out1 wrapped to 0: in1 beats in4
        next_cycle();
        req(1, 1); req(4, 1);
        wait_grant(g); check("t2_ptr_probe_a", g, 1); serve(g, 0);
        wait_grant(g); check("t2_ptr_probe_b", g, 4); serve(g, 0);

        // Fairness: in0 re-requests right after relieve while in3 waits
        next_cycle();
        req(0, 1); req(3, 1);
        wait_grant(g); check("t3_first", g, 0); serve(g, 1);
        wait_grant(g); check("t3_second", g, 3); serve(g, 0);
        wait_grant(g); check("t3_third", g, 0); serve(g, 0);

        // Parallel paths in0->out4, in1->out2
        next_cycle();
        req(0, 4); req(1, 2);
        wait_grant(g);
        check("t4_grant", grant, 5'b00011);
        check("t4_busy", output_busy, 5'b10100);
        next_cycle();
        relieve[0] = 1'b1; relieve[1] = 1'b1; req_valid[0] = 1'b0; req_valid[1] = 1'b0;
        next_cycle();
        relieve = '0;

        // Out-of-range destination is ignored
        next_cycle();
        req(2, 6);
        repeat (4) next_cycle();
        @(negedge clk);
        check("t5_bad_dest_grant", grant, 0);
        check("t5_bad_dest_busy", output_busy, 0);
        req_valid[2] = 1'b0;

        // Dropped request in WAIT is skipped by the arbiter
        next_cycle();
        req(0, 2);
        wait_grant(g); check("t5_hold_owner", g, 0);
        next_cycle();
        req(1, 2); req(3, 2);
        next_cycle();
        next_cycle();
        req_valid[1] = 1'b0;
        next_cycle();
        relieve[0] = 1'b1; req_valid[0] = 1'b0;
        next_cycle();
        relieve[0] = 1'b0;
        wait_grant(g); check("t5_skip_dropped", g, 3); serve(g, 0);

        // Reset during HOLD
        next_cycle();
        req(4, 0);
        wait_grant(g);
        next_cycle();
        next_cycle();
        rst = 1'b1; req_valid[4] = 1'b0;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("t5_rst_reserved", reserved, 0);
        check("t5_rst_busy", output_busy, 0);
        check("t5_rst_select", route_select, 0);

`ifdef SA_WATCHDOG_EN
        // Watchdog forced release after 8 HOLD cycles
        next_cycle();
        req(2, 3);
        wait_grant(g); check("t6_owner", g, 2);
        next_cycle();                        // first HOLD cycle
        req_valid[2] = 1'b0;
        req(1, 3);
        repeat (7) next_cycle();             // eighth HOLD cycle
        @(negedge clk);
        check("t6_no_err_yet", wdog_err, 0);
        next_cycle();
        @(negedge clk);
        check("t6_wdog_err", wdog_err, 5'b00100);
        check("t6_busy3", output_busy[3], 0);
        next_cycle();
        @(negedge clk);
        check("t6_regrant", grant, 5'b00010);
        serve(1, 0);
`endif

        repeat (3) next_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
